// File: rtl/eth_rx_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_filter_pkg
//  Purpose  : Shared types and constants for the MAC receive address filter.
//             Contains the filter state encoding, the header length and the
//             broadcast address.
//  Revision : 1.0 - initial release
// ============================================================================
package eth_rx_filter_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,   // collecting destination address bytes
    ST_PASS = 2'd1,   // frame accepted, stream body into the buffer
    ST_DROP = 2'd2    // frame rejected, ignore beats until tlast
  } rx_state_e;

  localparam int          HDR_LEN    = 6;
  localparam logic [47:0] BCAST_ADDR = 48'hffff_ffff_ffff;

endpackage
`default_nettype wire

// File: rtl/eth_mac_rx_addr_filter_if.sv
`default_nettype none
// ============================================================================
//  Module   : eth_mac_rx_addr_filter_if
//  Purpose  : Byte-wide AXI-stream bundle without tready, used on both the
//             receive input and the filtered output of the address filter.
//  Ports    : tdata  - byte
//             tvalid - byte valid
//             tlast  - last byte of frame
//             tuser  - frame error flag (meaningful with tlast)
//  Revision : 1.0 - initial release
// ============================================================================
interface eth_mac_rx_addr_filter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface
`default_nettype wire

// File: rtl/eth_rx_filter_ram.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_filter_ram
//  Purpose  : Simple dual-port frame buffer, one write port and one read port
//             with a registered read. Only the read register is reset, so the
//             downstream outputs are clean out of reset.
//  Ports    : clk, rst          - clock, async active-high reset
//             i_wr_en/addr/data - write port
//             i_rd_en/addr      - read request, data appears next cycle
//             o_rd_data         - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module eth_rx_filter_ram #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_mac_rx_addr_filter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_mac_rx_addr_filter
//  Purpose  : Destination-address filter for the MAC receive stream. Frames
//             are buffered in a small circular buffer; the header decides
//             whether the frame is committed for output or rewound away.
//  Ports    : clk, rst               - clock, async active-high reset
//             s_axis                 - receive stream from the MAC (no tready)
//             m_axis                 - filtered stream (no tready)
//             cfg_mac_addr           - local address, [47:40] is first byte
//             cfg_filter_enable      - 0 passes every frame
//             cfg_promiscuous        - accept every frame of >= 6 bytes
//             cfg_accept_broadcast   - accept ff:ff:ff:ff:ff:ff
//             cfg_accept_multicast   - accept DA with group bit set
//             stat_frame_accepted    - pulse per accepted frame
//             stat_frame_dropped     - pulse per dropped frame
//  Revision : 1.0 - initial release
// ============================================================================
module eth_mac_rx_addr_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  eth_mac_rx_addr_filter_if.slave          s_axis,
  eth_mac_rx_addr_filter_if.master         m_axis,
  input  logic [47:0]                      cfg_mac_addr,
  input  logic                             cfg_filter_enable,
  input  logic                             cfg_promiscuous,
  input  logic                             cfg_accept_broadcast,
  input  logic                             cfg_accept_multicast,
  output logic                             stat_frame_accepted,
  output logic                             stat_frame_dropped
);

  localparam logic [2:0] c_last_hdr = 3'(HDR_LEN - 1);

  rx_state_e        r_state;
  logic [2:0]       r_hdr_cnt;
  logic             r_uc;
  logic             r_bc;
  logic             r_mc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_commit_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_m_valid;

  logic [2:0]       w_sel;
  logic             w_byte_uc;
  logic             w_uc;
  logic             w_bc;
  logic             w_mc;
  logic             w_accept;
  logic             w_hdr_beat;
  logic             w_hdr_done;
  logic             w_runt;
  logic             w_keep;
  logic             w_reject;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [9:0]       w_rd_data;

  // Byte n of the DA compares with cfg_mac_addr[47-8n -: 8].
  assign w_sel     = c_last_hdr - r_hdr_cnt;
  assign w_byte_uc = (s_axis.tdata == cfg_mac_addr[{w_sel, 3'b000} +: 8]);

  // Flags include the current byte so the decision is ready on byte 6.
  assign w_uc = r_uc & w_byte_uc;
  assign w_bc = r_bc & (s_axis.tdata == BCAST_ADDR[7:0]);
  assign w_mc = (r_hdr_cnt == 3'd0) ? s_axis.tdata[0] : r_mc;

  assign w_accept = !cfg_filter_enable | cfg_promiscuous | w_uc
                  | (w_bc & cfg_accept_broadcast)
                  | (w_mc & cfg_accept_multicast);

  assign w_hdr_beat = s_axis.tvalid && (r_state == ST_HDR);
  assign w_hdr_done = w_hdr_beat && (r_hdr_cnt == c_last_hdr);
  assign w_runt     = w_hdr_beat && s_axis.tlast && !w_hdr_done;

  // A runt is only kept when filtering is off; promiscuous still needs 6 bytes.
  assign w_keep   = (w_hdr_done && w_accept) || (w_runt && !cfg_filter_enable);
  assign w_reject = (w_hdr_done && !w_accept) || (w_runt && cfg_filter_enable);

  assign w_wr_en      = s_axis.tvalid && (r_state != ST_DROP);
  assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
  assign w_rd_en      = (r_rd_ptr != r_commit_ptr);

  eth_rx_filter_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (10)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({s_axis.tdata, s_axis.tlast, s_axis.tuser}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign m_axis.tdata  = w_rd_data[9:2];
  assign m_axis.tlast  = w_rd_data[1];
  assign m_axis.tuser  = w_rd_data[0];
  assign m_axis.tvalid = r_m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state             <= ST_HDR;
      r_hdr_cnt           <= 3'd0;
      r_uc                <= 1'b1;
      r_bc                <= 1'b1;
      r_mc                <= 1'b1;
      r_wr_ptr            <= '0;
      r_commit_ptr        <= '0;
      r_rd_ptr            <= '0;
      r_m_valid           <= 1'b0;
      stat_frame_accepted <= 1'b0;
      stat_frame_dropped  <= 1'b0;
    end else begin
      stat_frame_accepted <= w_keep;
      stat_frame_dropped  <= w_reject;

      r_m_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      // A rejected header byte is written but the pointer falls back to the
      // last committed position, discarding the whole header.
      if (w_wr_en) begin
        r_wr_ptr <= w_reject ? r_commit_ptr : w_wr_ptr_inc;
        if (w_keep || (r_state == ST_PASS)) begin
          r_commit_ptr <= w_wr_ptr_inc;
        end
      end

      if (w_hdr_beat) begin
        if (w_hdr_done || s_axis.tlast) begin
          r_hdr_cnt <= 3'd0;
          r_uc      <= 1'b1;
          r_bc      <= 1'b1;
          r_mc      <= 1'b1;
        end else begin
          r_hdr_cnt <= r_hdr_cnt + 3'd1;
          r_uc      <= w_uc;
          r_bc      <= w_bc;
          r_mc      <= w_mc;
        end
      end

      case (r_state)
        ST_HDR: begin
          if (w_hdr_done && !s_axis.tlast) begin
            r_state <= w_accept ? ST_PASS : ST_DROP;
          end
        end
        ST_PASS, ST_DROP: begin
          if (s_axis.tvalid && s_axis.tlast) begin
            r_state <= ST_HDR;
          end
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

endmodule
`default_nettype wire
